noc_vc_output_port: RTL

//  Credit-based router output port with NUM_VC virtual channels. Crossbar flits are queued per VC.
//  A round-robin arbiter picks one eligible VC per cycle (FIFO non-empty and credit > 0) and

---
 rtl/noc_pkg.sv | 11 +
 rtl/noc_vc_fifo.sv | 46 ++++
 rtl/noc_vc_output_port.sv | 101 ++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit type, default NoC port constants and a VC-id width helper
package noc_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_VC = 2;
  localparam int DEPTH = 5;
  localparam int CREDITS = 5;
  typedef logic [DATA_W-1:0] flit_t;
  function automatic int vc_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/noc_vc_fifo.sv
// noc_vc_fifo: registered non-fall-through FIFO whose pointers wrap at DEPTH
module noc_vc_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign full_o = cnt_q == NW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + NW'(do_push) - NW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (!rst) assert (cnt_q <= NW'(DEPTH));
endmodule

// File: rtl/noc_vc_output_port.sv
// noc_vc_output_port: per-VC queued, credit-gated, round-robin arbitrated link output port
module noc_vc_output_port #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int DEPTH = noc_pkg::DEPTH,
  parameter int NUM_VC = noc_pkg::NUM_VC,
  parameter int CREDITS = noc_pkg::CREDITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_W-1:0]                   data_i,
  input  logic                                port_en,
  input  logic [noc_pkg::vc_w(NUM_VC)-1:0]    vc_i,
  input  logic [NUM_VC-1:0]                   inc_credit_i,
  output logic [DATA_W-1:0]                   data_o,
  output logic                                send_data,
  output logic [noc_pkg::vc_w(NUM_VC)-1:0]    vc_o,
  output logic [NUM_VC-1:0]                   full,
  output logic                                credit_err
);
  import noc_pkg::*;
  localparam int VW = vc_w(NUM_VC);
  localparam int CW = $clog2(CREDITS+1);
  localparam int NW = $clog2(DEPTH+1);
  typedef logic [VW-1:0] vc_id_t;
  typedef logic [CW-1:0] credit_t;
  logic [DATA_W-1:0] head [NUM_VC];
  logic [NW-1:0] cnt [NUM_VC];
  credit_t credit_q [NUM_VC];
  credit_t credit_d [NUM_VC];
  logic [NUM_VC-1:0] push, empty, elig, gnt, ovf;
  vc_id_t rr_q, gnt_vc;
  logic [DATA_W-1:0] data_q;
  vc_id_t vc_q;
  logic send_q, err_q, vc_ok, push_err;
  assign vc_ok = int'(vc_i) < NUM_VC;
  assign push_err = port_en && (vc_ok ? full[vc_i] : 1'b1);
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v] = port_en && vc_i == vc_id_t'(v) && !full[v];
    assign elig[v] = !empty[v] && credit_q[v] != '0;
    noc_vc_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push_i(push[v]), .pop_i(gnt[v]), .data_i(data_i),
      .data_o(head[v]), .full_o(full[v]), .empty_o(empty[v]), .count_o(cnt[v])
    );
  end
  // Scan from the highest offset down so the nearest eligible VC after rr_q wins.
  always_comb begin
    gnt = '0;
    gnt_vc = '0;
    for (int i = NUM_VC-1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_q) + i) % NUM_VC;
      if (elig[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_vc = vc_id_t'(idx);
      end
    end
  end
  always_comb begin
    ovf = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      int c;
      c = int'(credit_q[v]) + int'(inc_credit_i[v]) - int'(gnt[v]);
      ovf[v] = c > CREDITS;
      credit_d[v] = ovf[v] ? credit_t'(CREDITS) : credit_t'(c);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vc_q <= '0;
      send_q <= 1'b0;
      err_q <= 1'b0;
      rr_q <= '0;
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_t'(CREDITS);
    end else begin
      send_q <= |gnt;
      if (|gnt) begin
        data_q <= head[gnt_vc];
        vc_q <= gnt_vc;
        rr_q <= gnt_vc == vc_id_t'(NUM_VC-1) ? '0 : gnt_vc + 1'b1;
      end
      credit_q <= credit_d;
      err_q <= err_q || push_err || |ovf;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt));
      assert (!(|gnt) || credit_q[gnt_vc] != '0);
      for (int v = 0; v < NUM_VC; v++) begin
        assert (credit_q[v] <= credit_t'(CREDITS));
        assert (cnt[v] <= NW'(DEPTH));
      end
    end
  end
  assign data_o = data_q;
  assign send_data = send_q;
  assign vc_o = vc_q;
  assign credit_err = err_q;
endmodule
